// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply/divide unit.
// Op and FSM state encodings plus the default datapath width.
package cpu_pkg;

    localparam int MD_DATA_W = 16;

    typedef enum logic [1:0] {
        MD_SMUL = 2'b00,
        MD_UMUL = 2'b01,
        MD_SDIV = 2'b10,
        MD_UDIV = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// shift-subtract for divide, over a {hi, lo} register pair.
module muldiv_step #(
    parameter int DATA_W = 16
) (
    input  logic              is_div,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] shl;
    logic [DATA_W:0] diff;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        shl  = {hi_i, lo_i[DATA_W-1]};
        diff = shl - {1'b0, b_i};
        if (is_div) begin
            // diff MSB set means the trial subtraction borrowed
            hi_o = diff[DATA_W] ? shl[DATA_W-1:0] : diff[DATA_W-1:0];
            lo_o = {lo_i[DATA_W-2:0], ~diff[DATA_W]};
        end else begin
            hi_o = sum[DATA_W:1];
            lo_o = {sum[0], lo_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply-divide unit beside the EX ALU.
// Runs magnitudes through muldiv_step, then fixes signs in one cycle.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W    = MD_DATA_W,
    parameter bit SIGNED_EN = 1'b1,
    parameter int CNT_W     = $clog2(DATA_W) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              flush,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              busy,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_r0,
    output logic              div_by_zero,
    output logic              overflow
);

    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    md_state_e state_q, state_d;

    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [DATA_W-1:0] res_lo_q, res_lo_d, res_r0_q, res_r0_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic ovf_pend_q, ovf_pend_d, dbz_q, dbz_d, ovf_q, ovf_d;

    logic is_div_in, signed_in, sa, sb;
    logic launch, dbz_in, ovf_in, accept;
    logic [DATA_W-1:0]   abs_a, abs_b, step_hi, step_lo;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic [2*DATA_W-1:0] prod, prod_fix;

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div (is_div_q),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .b_i    (b_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        accept    = (state_q == MD_IDLE) || (state_q == MD_DONE);
        is_div_in = op[1];
        signed_in = SIGNED_EN && !op[0];
        sa        = signed_in && in1[DATA_W-1];
        sb        = signed_in && in2[DATA_W-1];
        abs_a     = sa ? -in1 : in1;
        abs_b     = sb ? -in2 : in2;
        launch    = start && !flush && accept;
        dbz_in    = is_div_in && (in2 == '0);
        ovf_in    = is_div_in && signed_in && (in1 == MIN_V) && (in2 == '1);
        prod      = {hi_q, lo_q};
        prod_fix  = neg_q_q ? -prod : prod;
        quo_fix   = neg_q_q ? -lo_q : lo_q;
        rem_fix   = neg_r_q ? -hi_q : hi_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE, MD_DONE: begin
                if (launch) state_d = dbz_in ? MD_DONE : MD_CALC;
                else        state_d = MD_IDLE;
            end
            MD_CALC: begin
                if (flush)                     state_d = MD_IDLE;
                else if (cnt_q == CNT_W'(1))   state_d = MD_FIX;
            end
            MD_FIX: state_d = flush ? MD_IDLE : MD_DONE;
        endcase
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        ovf_pend_d = ovf_pend_q;
        res_lo_d   = res_lo_q;
        res_r0_d   = res_r0_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        if (launch) begin
            hi_d       = '0;
            lo_d       = abs_a;
            b_d        = abs_b;
            cnt_d      = CNT_W'(DATA_W);
            is_div_d   = is_div_in;
            neg_q_d    = sa ^ sb;
            neg_r_d    = sa;
            ovf_pend_d = ovf_in;
            dbz_d      = dbz_in;
            ovf_d      = 1'b0;
            if (dbz_in) begin
                res_lo_d = '1;
                res_r0_d = in1;
            end
        end else if (state_q == MD_CALC) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == MD_FIX && !flush) begin
            ovf_d = ovf_pend_q;
            if (is_div_q) begin
                res_lo_d = quo_fix;
                res_r0_d = rem_fix;
            end else begin
                {res_r0_d, res_lo_d} = prod_fix;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            res_lo_q   <= '0;
            res_r0_q   <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            ovf_pend_q <= ovf_pend_d;
            res_lo_q   <= res_lo_d;
            res_r0_q   <= res_r0_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        busy        = (state_q == MD_CALC) || (state_q == MD_FIX);
        done        = (state_q == MD_DONE);
        stall_req   = (start && accept) || busy;
        result_lo   = res_lo_q;
        result_r0   = res_r0_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at DATA_W=16 plus an 8-bit instance.
// Cycle 1 is the cycle after the edge that samples start.
module tb_muldiv_unit;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        busy, stall_req, done, div_by_zero, overflow;
    logic [15:0] result_lo, result_r0;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, stall8, done8, dbz8, ovf8;
    logic [7:0]  lo8, r08;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    muldiv_unit #(.DATA_W(16), .SIGNED_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .flush(flush), .in1(in1), .in2(in2), .busy(busy),
        .stall_req(stall_req), .done(done), .result_lo(result_lo),
        .result_r0(result_r0), .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    muldiv_unit #(.DATA_W(8), .SIGNED_EN(1'b1)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8),
        .flush(1'b0), .in1(a8), .in2(b8), .busy(busy8),
        .stall_req(stall8), .done(done8), .result_lo(lo8),
        .result_r0(r08), .div_by_zero(dbz8), .overflow(ovf8)
    );

    task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({busy, stall_req, done, div_by_zero, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {busy, stall_req, done, div_by_zero, overflow});
        end
        checks++;
        if ({result_lo, result_r0} !== 32'h0) begin
            errors++;
            $display("FAIL reset_results: got %h want 00000000", {result_lo, result_r0});
        end
    endtask

    task automatic test_smul;
        int n;
        int bc;
        @(negedge clock);
        op = MD_SMUL; in1 = 16'hFFFD; in2 = 16'h0005; start = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            errors++;
            $display("FAIL smul_stall_at_start: got %b want 1", stall_req);
        end
        @(negedge clock);
        start = 1'b0;
        n = 1;
        bc = 0;
        while (!done && n < 60) begin
            if (busy && stall_req) bc++;
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL smul_latency: got %0d want 18", n);
        end
        checks++;
        if (bc !== 17) begin
            errors++;
            $display("FAIL smul_busy_cycles: got %0d want 17", bc);
        end
        checks++;
        if ({busy, stall_req} !== 2'b00) begin
            errors++;
            $display("FAIL smul_busy_at_done: got %b want 00", {busy, stall_req});
        end
        checks++;
        if ({result_r0, result_lo} !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL smul_result: got %h want ffff_fff1", {result_r0, result_lo});
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL smul_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_sdiv;
        int n;
        launch(MD_SDIV, 16'hFFF9, 16'h0002);
        wait_done(n);
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL sdiv_latency: got %0d want 18", n);
        end
        checks++;
        if ({result_lo, result_r0, overflow} !== {16'hFFFD, 16'hFFFF, 1'b0}) begin
            errors++;
            $display("FAIL sdiv_result: got %h %h ovf=%b want fffd ffff ovf=0", result_lo, result_r0, overflow);
        end
        launch(MD_SDIV, 16'h8000, 16'hFFFF);
        wait_done(n);
        checks++;
        if ({result_lo, result_r0, overflow, div_by_zero} !== {16'h8000, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sdiv_ovf: got %h %h ovf=%b dbz=%b want 8000 0000 ovf=1 dbz=0",
                     result_lo, result_r0, overflow, div_by_zero);
        end
    endtask

    task automatic test_umul;
        int n;
        launch(MD_UMUL, 16'hFFFF, 16'hFFFF);
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL umul_ovf_cleared_on_start: got %b want 0", overflow);
        end
        wait_done(n);
        checks++;
        if ({result_r0, result_lo, overflow, n} !== {16'hFFFE, 16'h0001, 1'b0, 32'd18}) begin
            errors++;
            $display("FAIL umul_result: got %h %h ovf=%b lat=%0d want fffe 0001 ovf=0 lat=18",
                     result_r0, result_lo, overflow, n);
        end
    endtask

    task automatic test_div_by_zero;
        int n;
        launch(MD_UDIV, 16'h1234, 16'h0000);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL dbz_latency: done=%b at cycle 1 want 1", done);
        end
        checks++;
        if ({result_lo, result_r0, div_by_zero, busy} !== {16'hFFFF, 16'h1234, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dbz_result: got %h %h dbz=%b busy=%b want ffff 1234 dbz=1 busy=0",
                     result_lo, result_r0, div_by_zero, busy);
        end
        launch(MD_UDIV, 16'd100, 16'd7);
        checks++;
        if ({div_by_zero, result_lo} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL dbz_clear_on_start: got dbz=%b lo=%h want dbz=0 lo=ffff", div_by_zero, result_lo);
        end
        wait_done(n);
        checks++;
        if ({result_lo, result_r0, n} !== {16'h000E, 16'h0002, 32'd18}) begin
            errors++;
            $display("FAIL udiv_result: got %h %h lat=%0d want 000e 0002 lat=18", result_lo, result_r0, n);
        end
    endtask

    task automatic test_flush;
        int seen;
        launch(MD_UMUL, 16'd3, 16'd4);
        repeat (4) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle: got busy/done %b want 00", {busy, done});
        end
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) seen++;
        end
        checks++;
        if ({seen, result_lo, result_r0} !== {32'd0, 16'h000E, 16'h0002}) begin
            errors++;
            $display("FAIL flush_retain: got done_cnt=%0d %h %h want 0 000e 0002", seen, result_lo, result_r0);
        end
        @(negedge clock);
        op = MD_UMUL; in1 = 16'd2; in2 = 16'd2; start = 1'b1; flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (20) begin
            if (busy || done) seen++;
            @(negedge clock);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_beats_start: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        launch(MD_UMUL, 16'd3, 16'd4);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, stall_req, done, div_by_zero, overflow, result_lo, result_r0} !== 37'h0) begin
            errors++;
            $display("FAIL reset_mid: got %b %h %h want all zero",
                     {busy, stall_req, done, div_by_zero, overflow}, result_lo, result_r0);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        int m;
        @(negedge clock);
        op = MD_UMUL; in1 = 16'd5; in2 = 16'd7; start = 1'b1;
        @(negedge clock);
        wait_done(n);
        checks++;
        if ({result_lo, result_r0, n} !== {16'd35, 16'd0, 32'd18}) begin
            errors++;
            $display("FAIL b2b_first: got %h %h lat=%0d want 0023 0000 lat=18", result_lo, result_r0, n);
        end
        op = MD_SMUL; in1 = 16'hFFFE; in2 = 16'h0003;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_relaunch: busy got %b want 1", busy);
        end
        wait_done(m);
        checks++;
        if ({result_lo, result_r0, m} !== {16'hFFFA, 16'hFFFF, 32'd18}) begin
            errors++;
            $display("FAIL b2b_second: got %h %h gap=%0d want fffa ffff gap=18", result_lo, result_r0, m);
        end
    endtask

    task automatic test_width8;
        int n;
        @(negedge clock);
        op8 = MD_UMUL; a8 = 8'hFF; b8 = 8'h02; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        n = 1;
        checks++;
        if ({busy8, stall8} !== 2'b11) begin
            errors++;
            $display("FAIL w8_busy: got %b want 11", {busy8, stall8});
        end
        while (!done8 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if ({r08, lo8, dbz8, ovf8, n} !== {8'h01, 8'hFE, 1'b0, 1'b0, 32'd10}) begin
            errors++;
            $display("FAIL w8_umul: got %h %h dbz=%b ovf=%b lat=%0d want 01 fe 0 0 lat=10",
                     r08, lo8, dbz8, ovf8, n);
        end
    endtask

    initial begin
        test_reset();
        test_smul();
        test_sdiv();
        test_umul();
        test_div_by_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
